// File: rtl/mobilenet_seq_pkg.sv
// mobilenet_seq_pkg: shared state encodings, error codes and defaults for the layer sequencer.
package mobilenet_seq_pkg;
   localparam int NUM_LAYERS_DEF = 29;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEEK = 3'd1,
      S_RUN  = 3'd2,
      S_HOLD = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_ABORT   = 2'd2;
   localparam logic [1:0] ERR_CFG     = 2'd3;
endpackage

// File: rtl/next_layer_finder.sv
// next_layer_finder: combinational search for the lowest unskipped layer in [ptr, last].
// Ports: ptr (search start, one bit wider so last+1 is representable), last (inclusive end),
//        skip_mask (1 = skip), found (a candidate exists), idx (lowest candidate).
module next_layer_finder #(
   parameter int LAYER_W    = 6,
   parameter int NUM_LAYERS = 29
) (
   input  logic [LAYER_W:0]      ptr,
   input  logic [LAYER_W-1:0]    last,
   input  logic [NUM_LAYERS-1:0] skip_mask,
   output logic                  found,
   output logic [LAYER_W-1:0]    idx
);
   // Scan downward so the last hit written is the lowest index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--)
         if (!skip_mask[i] && i >= int'(ptr) && i <= int'(last)) begin
            found = 1'b1;
            idx   = LAYER_W'(i);
         end
   end
endmodule

// File: rtl/layer_sequencer_ctrl.sv
// layer_sequencer_ctrl: runtime-configured layer walk driving layer_exec.
// Ports: CLK/RESETn (async active-low); start/abort/step_mode/step_go host controls;
//        cfg_* range, skip mask and per-layer watchdog (sampled only on launch);
//        layer_start/layer_id/layer_done handshake with layer_exec; bank_wr_sel/bank_rd_sel
//        ping-pong selects; busy/done/error/err_code/fsm_state status; cycle statistics.
module layer_sequencer_ctrl
   import mobilenet_seq_pkg::*;
#(
   parameter int LAYER_W    = 6,
   parameter int NUM_LAYERS = NUM_LAYERS_DEF,
   parameter int CYC_W      = 32
) (
   input  logic                  CLK,
   input  logic                  RESETn,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  step_mode,
   input  logic                  step_go,
   input  logic [LAYER_W-1:0]    cfg_first,
   input  logic [LAYER_W-1:0]    cfg_last,
   input  logic [NUM_LAYERS-1:0] cfg_skip_mask,
   input  logic [CYC_W-1:0]      cfg_timeout,
   output logic                  layer_start,
   output logic [LAYER_W-1:0]    layer_id,
   input  logic                  layer_done,
   output logic                  bank_wr_sel,
   output logic                  bank_rd_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [2:0]            fsm_state,
   output logic [LAYER_W:0]      layers_run,
   output logic [CYC_W-1:0]      last_layer_cycles,
   output logic [CYC_W-1:0]      total_cycles
);
   state_t                  state;
   logic [LAYER_W:0]        ptr;
   logic [LAYER_W-1:0]      sh_last;
   logic [NUM_LAYERS-1:0]   sh_mask;
   logic [CYC_W-1:0]        sh_timeout;
   logic [CYC_W-1:0]        layer_cyc;
   logic                    found;
   logic [LAYER_W-1:0]      idx;

   next_layer_finder #(.LAYER_W(LAYER_W), .NUM_LAYERS(NUM_LAYERS)) u_finder (
      .ptr       (ptr),
      .last      (sh_last),
      .skip_mask (sh_mask),
      .found     (found),
      .idx       (idx)
   );

   assign busy      = state inside {S_SEEK, S_RUN, S_HOLD};
   assign done      = state == S_DONE;
   assign error     = state == S_ERR;
   assign fsm_state = state;

   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) begin
         state             <= S_IDLE;
         ptr               <= '0;
         sh_last           <= '0;
         sh_mask           <= '0;
         sh_timeout        <= '0;
         layer_cyc         <= '0;
         layer_start       <= 1'b0;
         layer_id          <= '0;
         bank_wr_sel       <= 1'b0;
         bank_rd_sel       <= 1'b1;
         err_code          <= ERR_NONE;
         layers_run        <= '0;
         last_layer_cycles <= '0;
         total_cycles      <= '0;
      end else begin
         layer_start <= 1'b0;
         if (busy && total_cycles != '1)
            total_cycles <= total_cycles + 1'b1;
         if (busy && abort) begin
            state    <= S_ERR;
            err_code <= ERR_ABORT;
         end else
            case (state)
               S_IDLE:
                  if (start) begin
                     ptr               <= {1'b0, cfg_first};
                     sh_last           <= cfg_last;
                     sh_mask           <= cfg_skip_mask;
                     sh_timeout        <= cfg_timeout;
                     layers_run        <= '0;
                     last_layer_cycles <= '0;
                     total_cycles      <= '0;
                     bank_wr_sel       <= 1'b0;
                     bank_rd_sel       <= 1'b1;
                     if (cfg_first > cfg_last || int'(cfg_last) >= NUM_LAYERS) begin
                        state    <= S_ERR;
                        err_code <= ERR_CFG;
                     end else begin
                        state    <= S_SEEK;
                        err_code <= ERR_NONE;
                     end
                  end
               S_SEEK:
                  if (found) begin
                     layer_id    <= idx;
                     layer_start <= 1'b1;
                     layer_cyc   <= CYC_W'(1);
                     state       <= S_RUN;
                  end else
                     state <= S_DONE;
               S_RUN: begin
                  layer_cyc <= layer_cyc + 1'b1;
                  // A done coinciding with the launch pulse belongs to a previous layer.
                  if (layer_done && !layer_start) begin
                     last_layer_cycles <= layer_cyc;
                     layers_run        <= layers_run + 1'b1;
                     bank_wr_sel       <= ~bank_wr_sel;
                     bank_rd_sel       <= ~bank_rd_sel;
                     ptr               <= {1'b0, layer_id} + 1'b1;
                     state             <= step_mode ? S_HOLD : S_SEEK;
                  end else if (sh_timeout != '0 && layer_cyc == sh_timeout) begin
                     state    <= S_ERR;
                     err_code <= ERR_TIMEOUT;
                  end
               end
               S_HOLD:
                  if (step_go || !step_mode)
                     state <= S_SEEK;
               default:
                  if (!start)
                     state <= S_IDLE;
            endcase
      end
endmodule
